// File: rtl/stack_arbiter_pkg.sv
// Shared types and constants for the two-requester hardware stack arbiter.
package stack_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int LAST_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic [LAST_W-1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [LAST_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = LAST_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stack_arbiter_rr_picker.sv
// Round-robin picker: the requester after the last served one wins first.
module rr_picker
  import stack_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [LAST_W-1:0]  last,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates processor and loader access to a hardware stack, one op per 4 cycles.
// Optional STACK_ARBITER_LOCK_EN adds a lock input for atomic multi-op sequences.
//
// state      | meaning
// ST_IDLE    | wait for a request, pick winner, latch op/wdata
// ST_ISSUE   | one-cycle push or pop strobe to the stack
// ST_CAPTURE | register popped word from stack_data_in
// ST_DONE    | pulse done/err to winner, advance round-robin pointer
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
`ifdef STACK_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          stack_push,
  output logic                          stack_pop,
  output logic [DATA_WIDTH-1:0]         stack_data_out,
  input  logic [DATA_WIDTH-1:0]         stack_data_in,
  input  logic                          stack_full,
  input  logic                          stack_empty
);

  state_t                 state, state_nxt;
  logic [NUM_REQ-1:0]     winner_q;
  logic                   op_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   refused_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [LAST_W-1:0]      last_q;

  logic [NUM_REQ-1:0]     rr_oh;
  logic [NUM_REQ-1:0]     sel_oh;
  logic [LAST_W-1:0]      sel_idx;
  logic                   sel_op;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_refuse;
  logic [LAST_W-1:0]      win_idx;

`ifdef STACK_ARBITER_LOCK_EN
  logic                   lock_q;
`endif

  rr_picker u_rr_picker (
    .req    (req),
    .last   (last_q),
    .winner (rr_oh)
  );

  // A held lock overrides round-robin while the locked requester keeps asking.
  always_comb begin
    sel_oh = rr_oh;
`ifdef STACK_ARBITER_LOCK_EN
    if (lock_q && |(req & winner_q)) sel_oh = winner_q;
`endif
  end

  always_comb begin
    sel_idx    = oh_to_idx(sel_oh);
    sel_op     = op[sel_idx];
    sel_wdata  = wdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_refuse = (sel_op == OP_PUSH) ? stack_full : stack_empty;
    win_idx    = oh_to_idx(winner_q);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|sel_oh) state_nxt = sel_refuse ? ST_CAPTURE : ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      winner_q  <= '0;
      op_q      <= OP_POP;
      wdata_q   <= '0;
      refused_q <= 1'b0;
      rdata_q   <= '0;
      last_q    <= LAST_W'(NUM_REQ - 1);
`ifdef STACK_ARBITER_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef STACK_ARBITER_LOCK_EN
          lock_q <= 1'b0;
`endif
          if (|sel_oh) begin
            winner_q  <= sel_oh;
            op_q      <= sel_op;
            wdata_q   <= sel_wdata;
            refused_q <= sel_refuse;
          end
        end
        ST_CAPTURE: begin
          rdata_q <= (op_q == OP_POP && !refused_q) ? stack_data_in : '0;
        end
        ST_DONE: begin
          rdata_q <= '0;
`ifdef STACK_ARBITER_LOCK_EN
          if (lock[win_idx]) lock_q <= 1'b1;
          else               last_q <= win_idx;
`else
          last_q <= win_idx;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt            = (state != ST_IDLE) ? winner_q : '0;
    done           = (state == ST_DONE) ? winner_q : '0;
    err            = (state == ST_DONE && refused_q) ? winner_q : '0;
    rdata          = rdata_q;
    stack_push     = (state == ST_ISSUE) && (op_q == OP_PUSH);
    stack_pop      = (state == ST_ISSUE) && (op_q == OP_POP);
    stack_data_out = stack_push ? wdata_q : '0;
  end

endmodule
